uart_ns_rx: RTL and testbench

UART receive stage, the line-side counterpart of the UART transmitter in the same peripheral. It deserialises 8N1/8N2 frames from the rx pin into bytes. It uses the same baud divisor semantics as the TX, so one bit period is baud_div_i clk cycles. Received bytes are presented on a valid/ready handshake to the register/FIFO layer, with per-byte framing error and an overrun pulse.

---
 rtl/uart_ns_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_ns_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_ns_rx.sv
// UART receive stage: deserialises 8N1/8N2 frames from an asynchronous rx pin
// and presents each byte on a valid/ready handshake with framing and overrun status.
module uart_ns_rx #(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_pin_i,
    input  logic [BAUD_DIV_W-1:0] baud_div_i,
    input  logic                  two_stop_bits_i,
    output logic [DATA_W-1:0]     rx_data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_err_o,
    output logic                  overrun_o
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP1,
        ST_STOP2,
        ST_DELIVER
    } state_t;

    state_t                state_q;
    logic                  rx_meta_q;
    logic                  rx_sync_q;
    logic                  rx_prev_q;
    logic [BAUD_DIV_W-1:0] cnt_q;
    logic [IDX_W-1:0]      bit_idx_q;
    logic [DATA_W-1:0]     shift_q;
    logic                  ferr_q;
    logic [DATA_W-1:0]     rx_data_q;
    logic                  valid_q;
    logic                  frame_err_q;
    logic                  overrun_q;

    logic                  sample_s;
    logic                  start_edge_s;
    logic                  accept_s;

    // Sample strobe, start edge and consumer handshake decode
    always_comb begin
        sample_s     = 1'b0;
        start_edge_s = 1'b0;
        accept_s     = 1'b0;
        // <= 1 rather than == 1 so an illegal divisor of 0 still makes progress
        if (cnt_q <= BAUD_DIV_W'(1)) begin
            sample_s = 1'b1;
        end else begin
            sample_s = 1'b0;
        end
        start_edge_s = ~rx_sync_q & rx_prev_q;
        accept_s     = valid_q & ready_i;
    end

    // Synchroniser, receive FSM and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            ferr_q      <= 1'b0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_pin_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            overrun_q <= 1'b0;
            if (accept_s) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        cnt_q   <= baud_div_i >> 1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (sample_s) begin
                        cnt_q <= baud_div_i;
                        if (!rx_sync_q) begin
                            bit_idx_q <= '0;
                            ferr_q    <= 1'b0;
                            state_q   <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - BAUD_DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (sample_s) begin
                        cnt_q   <= baud_div_i;
                        shift_q <= {rx_sync_q, shift_q[DATA_W-1:1]};
                        if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                            state_q <= ST_STOP1;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - BAUD_DIV_W'(1);
                    end
                end
                ST_STOP1: begin
                    if (sample_s) begin
                        cnt_q   <= baud_div_i;
                        ferr_q  <= ferr_q | ~rx_sync_q;
                        state_q <= two_stop_bits_i ? ST_STOP2 : ST_DELIVER;
                    end else begin
                        cnt_q <= cnt_q - BAUD_DIV_W'(1);
                    end
                end
                ST_STOP2: begin
                    if (sample_s) begin
                        cnt_q   <= baud_div_i;
                        ferr_q  <= ferr_q | ~rx_sync_q;
                        state_q <= ST_DELIVER;
                    end else begin
                        cnt_q <= cnt_q - BAUD_DIV_W'(1);
                    end
                end
                ST_DELIVER: begin
                    // A byte still held unconsumed wins; the new one is dropped
                    if (!valid_q || accept_s) begin
                        rx_data_q   <= shift_q;
                        frame_err_q <= ferr_q;
                        valid_q     <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data_o   = rx_data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_ns_rx.sv
// Directed bench for uart_ns_rx: frames driven on the pin bit by bit, outputs
// compared against hand-computed bytes, flags and latencies.
module tb_uart_ns_rx;

    logic        clk;
    logic        rst_n;
    logic        rx_pin;
    logic [15:0] baud_div;
    logic        two_stop;
    logic [7:0]  rx_data;
    logic        valid;
    logic        ready;
    logic        frame_err;
    logic        overrun;

    int          n_checks;
    int          n_errors;
    int          cyc;
    int          frame_p;
    int          rise_cyc;
    int          ovr_cycles;
    int          ovr_base;
    int          acc_base;
    logic        valid_prev;
    logic [8:0]  acc[$];

    uart_ns_rx #(.DATA_W(8), .BAUD_DIV_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_pin_i        (rx_pin),
        .baud_div_i      (baud_div),
        .two_stop_bits_i (two_stop),
        .rx_data_o       (rx_data),
        .valid_o         (valid),
        .ready_i         (ready),
        .frame_err_o     (frame_err),
        .overrun_o       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: valid rise time, accepted bytes and overrun cycles
    always begin
        @(negedge clk);
        #2;
        if (valid && !valid_prev) rise_cyc = cyc;
        valid_prev = valid;
        if (valid && ready) acc.push_back({frame_err, rx_data});
        if (overrun) ovr_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the pin level is first sampled at posedge frame_p
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        frame_p = cyc + 1;
        rx_pin = 1'b0;
        repeat (baud_div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (baud_div) @(negedge clk);
        end
        rx_pin = stop_v;
        repeat (baud_div) @(negedge clk);
        if (two_stop) begin
            repeat (baud_div) @(negedge clk);
        end
    endtask

    task automatic consume();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; rise_cyc = -1;
        ovr_cycles = 0; valid_prev = 1'b0;
        rst_n = 1'b0; rx_pin = 1'b1; baud_div = 16'd16; two_stop = 1'b0; ready = 1'b0;
        idle(4);
        check_eq("reset_valid", {31'd0, valid}, 32'd0);
        check_eq("reset_data", {24'd0, rx_data}, 32'd0);
        check_eq("reset_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("reset_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // 8N1 0xA5, held then consumed
        send_frame(8'hA5, 1'b1);
        check_eq("a5_latency", rise_cyc - frame_p, 32'd155);
        check_eq("a5_data", {24'd0, rx_data}, 32'hA5);
        check_eq("a5_ferr", {31'd0, frame_err}, 32'd0);
        idle(20);
        check_eq("a5_hold_valid", {31'd0, valid}, 32'd1);
        check_eq("a5_hold_data", {24'd0, rx_data}, 32'hA5);
        consume();
        check_eq("a5_cleared", {31'd0, valid}, 32'd0);
        idle(10);

        // 8N2 0x3C then 0xFF back to back, consumer always ready
        two_stop = 1'b1; ready = 1'b1;
        acc_base = acc.size(); ovr_base = ovr_cycles;
        send_frame(8'h3C, 1'b1);
        check_eq("3c_latency", rise_cyc - frame_p, 32'd171);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check_eq("b2b_count", acc.size() - acc_base, 32'd2);
        check_eq("b2b_first", {23'd0, acc[acc_base]}, 32'h03C);
        check_eq("b2b_second", {23'd0, acc[acc_base + 1]}, 32'h0FF);
        check_eq("b2b_no_ovr", ovr_cycles - ovr_base, 32'd0);
        two_stop = 1'b0;

        // 4-cycle low glitch, then a real 0x55 frame
        acc_base = acc.size();
        rx_pin = 1'b0; idle(4); rx_pin = 1'b1;
        idle(40);
        check_eq("glitch_no_valid", {31'd0, valid}, 32'd0);
        check_eq("glitch_no_byte", acc.size() - acc_base, 32'd0);
        send_frame(8'h55, 1'b1);
        idle(20);
        check_eq("55_count", acc.size() - acc_base, 32'd1);
        check_eq("55_data", {23'd0, acc[acc.size() - 1]}, 32'h055);

        // Stop bit low on 0x81, then a 3-bit-time break
        ready = 1'b0; ovr_base = ovr_cycles;
        send_frame(8'h81, 1'b0);
        idle(48);
        rx_pin = 1'b1;
        idle(40);
        check_eq("81_valid", {31'd0, valid}, 32'd1);
        check_eq("81_data", {24'd0, rx_data}, 32'h81);
        check_eq("81_ferr", {31'd0, frame_err}, 32'd1);
        check_eq("break_no_byte", ovr_cycles - ovr_base, 32'd0);
        consume();
        idle(5);
        check_eq("81_cleared", {31'd0, valid}, 32'd0);

        // Overrun: 0x22 arrives while 0x11 is still held
        ovr_base = ovr_cycles;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(10);
        check_eq("ovr_data_kept", {24'd0, rx_data}, 32'h11);
        check_eq("ovr_one_pulse", ovr_cycles - ovr_base, 32'd1);
        consume();
        idle(5);

        // Same pair, consumer ready exactly in the DELIVER cycle of 0x22
        send_frame(8'h11, 1'b1);
        ovr_base = ovr_cycles; acc_base = acc.size();
        fork
            send_frame(8'h22, 1'b1);
            begin
                idle(155);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        idle(10);
        check_eq("swap_data", {24'd0, rx_data}, 32'h22);
        check_eq("swap_valid", {31'd0, valid}, 32'd1);
        check_eq("swap_no_ovr", ovr_cycles - ovr_base, 32'd0);
        check_eq("swap_took_11", {23'd0, acc[acc_base]}, 32'h011);
        consume();
        idle(5);

        // Reset during data bit 4, held until the line is idle again
        send_frame(8'h5A, 1'b1);
        check_eq("pre_rst_valid", {31'd0, valid}, 32'd1);
        fork
            send_frame(8'h0F, 1'b1);
            begin
                idle(85);
                rst_n = 1'b0;
                @(negedge clk);
                check_eq("rst_valid", {31'd0, valid}, 32'd0);
                check_eq("rst_data", {24'd0, rx_data}, 32'd0);
                check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
            end
        join
        rst_n = 1'b1;
        idle(40);
        check_eq("post_rst_valid", {31'd0, valid}, 32'd0);
        ready = 1'b1; acc_base = acc.size();
        send_frame(8'hC3, 1'b1);
        idle(20);
        check_eq("c3_count", acc.size() - acc_base, 32'd1);
        check_eq("c3_data", {23'd0, acc[acc.size() - 1]}, 32'h0C3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
